// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer
// Front-end controller for the MLP accelerator. Takes the packed DRAM word
// stream (ifmap, weights, bias for each of two steps), steers every accepted
// word to the matching global buffer with a registered strobe/address/data,
// kicks the PE array after each step's bias segment and reports job done.
// Optional build macro: SEQ_TIMEOUT_EN adds a RUN-state watchdog that sets
// the sticky err flag and abandons the job after TIMEOUT_CYCLES.
module mlp_load_sequencer #(
    parameter int DATA_W         = 32,
    parameter int IF_WORDS       = 16,
    parameter int W_WORDS        = 1024,
    parameter int B_WORDS        = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            data_in,
    output logic                         ifmap_we,
    output logic                         weight_we,
    output logic                         bias_we,
    output logic [$clog2(IF_WORDS)-1:0]  ifmap_addr,
    output logic [$clog2(W_WORDS)-1:0]   weight_addr,
    output logic [$clog2(B_WORDS)-1:0]   bias_addr,
    output logic [DATA_W-1:0]            wdata,
    output logic                         mode_q,
    output logic                         step,
    output logic                         compute_start,
    input  logic                         compute_done,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int IF_AW = $clog2(IF_WORDS);
    localparam int W_AW  = $clog2(W_WORDS);
    localparam int B_AW  = $clog2(B_WORDS);
    localparam int MX_AW = (IF_AW > B_AW) ? IF_AW : B_AW;
    localparam int CNT_W = (W_AW > MX_AW) ? W_AW : MX_AW;

    localparam logic [CNT_W-1:0] IF_LAST = CNT_W'(IF_WORDS - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(W_WORDS - 1);
    localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(B_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_IF = 3'd1,
        ST_LD_W  = 3'd2,
        ST_LD_B  = 3'd3,
        ST_KICK  = 3'd4,
        ST_RUN   = 3'd5
    } state_t;

    state_t              state_r, next_state_s;
    logic [CNT_W-1:0]    seg_cnt_r, seg_cnt_s;
    logic                step_r, step_s;
    logic                in_ready_r, busy_r, done_r, compute_start_r, mode_q_r;
    logic                ifmap_we_r, weight_we_r, bias_we_r;
    logic [IF_AW-1:0]    ifmap_addr_r;
    logic [W_AW-1:0]     weight_addr_r;
    logic [B_AW-1:0]     bias_addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                word_s, accept_s, if_wr_s, w_wr_s, b_wr_s;
    logic                kick_s, done_s, job_start_s;

    // in_ready is a register driven from the state only, so this is the handshake
    assign word_s = in_valid && in_ready_r;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]     run_cnt_r;
    logic                timeout_s;
    logic                err_r;
`endif

    // Next-state, segment counter and write-strobe decode; abort overrides all
    always_comb begin
        next_state_s = state_r;
        seg_cnt_s    = seg_cnt_r;
        step_s       = step_r;
        accept_s     = 1'b0;
        if_wr_s      = 1'b0;
        w_wr_s       = 1'b0;
        b_wr_s       = 1'b0;
        kick_s       = 1'b0;
        done_s       = 1'b0;
        job_start_s  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        timeout_s    = 1'b0;
`endif
        if (abort) begin
            next_state_s = ST_IDLE;
            seg_cnt_s    = '0;
            step_s       = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // the cycle carrying done is not a legal start cycle
                    if (start && !done_r) begin
                        job_start_s  = 1'b1;
                        step_s       = 1'b0;
                        seg_cnt_s    = '0;
                        next_state_s = ST_LD_IF;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_LD_IF: begin
                    if (word_s) begin
                        accept_s = 1'b1;
                        if_wr_s  = 1'b1;
                        if (seg_cnt_r == IF_LAST) begin
                            seg_cnt_s    = '0;
                            next_state_s = ST_LD_W;
                        end else begin
                            seg_cnt_s = seg_cnt_r + 1'b1;
                        end
                    end else begin
                        seg_cnt_s = seg_cnt_r;
                    end
                end
                ST_LD_W: begin
                    if (word_s) begin
                        accept_s = 1'b1;
                        w_wr_s   = 1'b1;
                        if (seg_cnt_r == W_LAST) begin
                            seg_cnt_s    = '0;
                            next_state_s = ST_LD_B;
                        end else begin
                            seg_cnt_s = seg_cnt_r + 1'b1;
                        end
                    end else begin
                        seg_cnt_s = seg_cnt_r;
                    end
                end
                ST_LD_B: begin
                    if (word_s) begin
                        accept_s = 1'b1;
                        b_wr_s   = 1'b1;
                        if (seg_cnt_r == B_LAST) begin
                            seg_cnt_s    = '0;
                            kick_s       = 1'b1;
                            next_state_s = ST_KICK;
                        end else begin
                            seg_cnt_s = seg_cnt_r + 1'b1;
                        end
                    end else begin
                        seg_cnt_s = seg_cnt_r;
                    end
                end
                ST_KICK: begin
                    next_state_s = ST_RUN;
                end
                ST_RUN: begin
                    if (compute_done) begin
                        if (!step_r) begin
                            step_s       = 1'b1;
                            next_state_s = ST_LD_IF;
                        end else begin
                            done_s       = 1'b1;
                            step_s       = 1'b0;
                            next_state_s = ST_IDLE;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (run_cnt_r == TO_LAST) begin
                        timeout_s    = 1'b1;
                        step_s       = 1'b0;
                        next_state_s = ST_IDLE;
                    end
`endif
                    else begin
                        next_state_s = ST_RUN;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    seg_cnt_s    = '0;
                    step_s       = 1'b0;
                end
            endcase
        end
    end

    // State, counters and all externally visible control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            seg_cnt_r       <= '0;
            step_r          <= 1'b0;
            in_ready_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            compute_start_r <= 1'b0;
            mode_q_r        <= 1'b0;
            ifmap_we_r      <= 1'b0;
            weight_we_r     <= 1'b0;
            bias_we_r       <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            seg_cnt_r       <= seg_cnt_s;
            step_r          <= step_s;
            in_ready_r      <= (next_state_s == ST_LD_IF) || (next_state_s == ST_LD_W) ||
                               (next_state_s == ST_LD_B);
            busy_r          <= (next_state_s != ST_IDLE);
            done_r          <= done_s;
            compute_start_r <= kick_s;
            ifmap_we_r      <= if_wr_s;
            weight_we_r     <= w_wr_s;
            bias_we_r       <= b_wr_s;
            if (job_start_s) begin
                mode_q_r <= mode;
            end
        end
    end

    // Write address/data capture; the address is the segment counter at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifmap_addr_r  <= '0;
            weight_addr_r <= '0;
            bias_addr_r   <= '0;
            wdata_r       <= '0;
        end else begin
            if (accept_s) begin
                wdata_r <= data_in;
            end
            if (if_wr_s) begin
                ifmap_addr_r <= seg_cnt_r[IF_AW-1:0];
            end
            if (w_wr_s) begin
                weight_addr_r <= seg_cnt_r[W_AW-1:0];
            end
            if (b_wr_s) begin
                bias_addr_r <= seg_cnt_r[B_AW-1:0];
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // RUN-cycle watchdog counter (held at zero outside RUN) and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (state_r == ST_RUN) begin
                run_cnt_r <= run_cnt_r + 1'b1;
            end else begin
                run_cnt_r <= '0;
            end
            if (job_start_s) begin
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign in_ready      = in_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign compute_start = compute_start_r;
    assign mode_q        = mode_q_r;
    assign step          = step_r;
    assign ifmap_we      = ifmap_we_r;
    assign weight_we     = weight_we_r;
    assign bias_we       = bias_we_r;
    assign ifmap_addr    = ifmap_addr_r;
    assign weight_addr   = weight_addr_r;
    assign bias_addr     = bias_addr_r;
    assign wdata         = wdata_r;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Self-checking bench for mlp_load_sequencer: a job-level reference model
// (phase + word index within a step) predicts every output each cycle.
module tb_mlp_load_sequencer;

    localparam int NIF  = 16;
    localparam int NW   = 1024;
    localparam int NB   = 64;
    localparam int TOT  = NIF + NW + NB;
    localparam int TOUT = 64;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_KICK = 2;
    localparam int P_RUN  = 3;

    logic        clk = 1'b0;
    logic        rst, mode, start, abort, in_valid, compute_done;
    logic [31:0] data_in;
    logic        in_ready, ifmap_we, weight_we, bias_we, mode_q, step;
    logic        compute_start, busy, done, err;
    logic [3:0]  ifmap_addr;
    logic [9:0]  weight_addr;
    logic [5:0]  bias_addr;
    logic [31:0] wdata;

    mlp_load_sequencer #(
        .DATA_W(32), .IF_WORDS(NIF), .W_WORDS(NW), .B_WORDS(NB), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .ifmap_we(ifmap_we), .weight_we(weight_we), .bias_we(bias_we),
        .ifmap_addr(ifmap_addr), .weight_addr(weight_addr), .bias_addr(bias_addr),
        .wdata(wdata), .mode_q(mode_q), .step(step), .compute_start(compute_start),
        .compute_done(compute_done), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_phase = P_IDLE;
    int          m_idx   = 0;
    int          m_run   = 0;
    logic        m_step  = 1'b0;
    logic        m_mode  = 1'b0;
    logic        m_err   = 1'b0;
    logic        ex_if_we = 1'b0, ex_w_we = 1'b0, ex_b_we = 1'b0;
    logic        ex_cs = 1'b0, ex_done = 1'b0;
    logic [3:0]  ex_if_addr = 4'd0;
    logic [9:0]  ex_w_addr  = 10'd0;
    logic [5:0]  ex_b_addr  = 6'd0;
    logic [31:0] ex_data    = 32'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_phase = P_IDLE; m_idx = 0; m_run = 0; m_step = 1'b0; m_mode = 1'b0; m_err = 1'b0;
                ex_if_we = 1'b0; ex_w_we = 1'b0; ex_b_we = 1'b0; ex_cs = 1'b0; ex_done = 1'b0;
                ex_if_addr = 4'd0; ex_w_addr = 10'd0; ex_b_addr = 6'd0; ex_data = 32'd0;
            end else begin
                logic prev_done;
                prev_done = ex_done;
                ex_if_we = 1'b0; ex_w_we = 1'b0; ex_b_we = 1'b0; ex_cs = 1'b0; ex_done = 1'b0;
                if (abort) begin
                    m_phase = P_IDLE; m_idx = 0; m_step = 1'b0;
                end else if (m_phase == P_IDLE) begin
                    if (start && !prev_done) begin
                        m_mode = mode; m_step = 1'b0; m_err = 1'b0; m_idx = 0; m_phase = P_LOAD;
                    end
                end else if (m_phase == P_LOAD) begin
                    if (in_valid) begin
                        ex_data = data_in;
                        if (m_idx < NIF) begin
                            ex_if_we = 1'b1; ex_if_addr = 4'(m_idx);
                        end else if (m_idx < NIF + NW) begin
                            ex_w_we = 1'b1; ex_w_addr = 10'(m_idx - NIF);
                        end else begin
                            ex_b_we = 1'b1; ex_b_addr = 6'(m_idx - NIF - NW);
                        end
                        m_idx++;
                        if (m_idx == TOT) begin
                            m_idx = 0; m_phase = P_KICK; ex_cs = 1'b1;
                        end
                    end
                end else if (m_phase == P_KICK) begin
                    m_phase = P_RUN; m_run = 0;
                end else begin
                    if (compute_done) begin
                        if (!m_step) begin
                            m_step = 1'b1; m_phase = P_LOAD;
                        end else begin
                            ex_done = 1'b1; m_step = 1'b0; m_phase = P_IDLE;
                        end
                    end else begin
`ifdef SEQ_TIMEOUT_EN
                        m_run++;
                        if (m_run == TOUT) begin
                            m_err = 1'b1; m_step = 1'b0; m_phase = P_IDLE;
                        end
`endif
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_if = 0, n_w = 0, n_b = 0, n_cs = 0, n_done = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", 64'(in_ready), 64'(m_phase == P_LOAD));
            check("busy", 64'(busy), 64'(m_phase != P_IDLE));
            check("step", 64'(step), 64'(m_step));
            check("mode_q", 64'(mode_q), 64'(m_mode));
            check("err", 64'(err), 64'(m_err));
            check("done", 64'(done), 64'(ex_done));
            check("compute_start", 64'(compute_start), 64'(ex_cs));
            check("ifmap_we", 64'(ifmap_we), 64'(ex_if_we));
            check("weight_we", 64'(weight_we), 64'(ex_w_we));
            check("bias_we", 64'(bias_we), 64'(ex_b_we));
            if (ex_if_we) check("ifmap_addr", 64'(ifmap_addr), 64'(ex_if_addr));
            if (ex_w_we)  check("weight_addr", 64'(weight_addr), 64'(ex_w_addr));
            if (ex_b_we)  check("bias_addr", 64'(bias_addr), 64'(ex_b_addr));
            if (ex_if_we || ex_w_we || ex_b_we) check("wdata", 64'(wdata), 64'(ex_data));
            if (ifmap_we)      n_if++;
            if (weight_we)     n_w++;
            if (bias_we)       n_b++;
            if (compute_start) n_cs++;
            if (done)          n_done++;
        end
    end

    // ---------------- stream source and PE-array responder ----------------
    int   valid_mode  = 0;
    int   cd_delay    = 20;
    int   cd_pending  = 0;
    logic cd_withhold = 1'b0;
    logic stray_cd    = 1'b0;

    initial begin
        in_valid = 1'b0; data_in = 32'd0; compute_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (valid_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ~in_valid;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            data_in = $urandom;
            compute_done = 1'b0;
            if (cd_pending > 0) begin
                cd_pending--;
                if (cd_pending == 0) compute_done = 1'b1;
            end
            if (stray_cd) begin
                compute_done = 1'b1;
                stray_cd = 1'b0;
            end
            if (compute_start && !cd_withhold) cd_pending = cd_delay;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_if = 0; n_w = 0; n_b = 0; n_cs = 0; n_done = 0;
    endtask

    task automatic start_job(input logic m);
        clear_counts();
        mode = m; start = 1'b1;
        cyc(1);
        start = 1'b0; mode = $urandom_range(0, 1) != 0;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin
            cyc(1);
            k++;
        end
        check("job_finished_in_budget", 64'(busy), 64'd0);
        cyc(2);
    endtask

    task automatic wait_idx(input int target, input int limit);
        int k = 0;
        while (!(m_phase == P_LOAD && m_idx == target) && k < limit) begin
            cyc(1);
            k++;
        end
        check("reached_word_index", 64'(m_idx), 64'(target));
    endtask

    task automatic check_full_job(input string tag);
        check({tag, "_ifmap_writes"}, 64'(n_if), 64'd32);
        check({tag, "_weight_writes"}, 64'(n_w), 64'd2048);
        check({tag, "_bias_writes"}, 64'(n_b), 64'd128);
        check({tag, "_kicks"}, 64'(n_cs), 64'd2);
        check({tag, "_dones"}, 64'(n_done), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; mode = 1'b0; start = 1'b0; abort = 1'b0;
        cyc(3);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_wdata", 64'(wdata), 64'd0);
        rst = 1'b1;
        cyc(2);

        // mode 0, continuous stream
        valid_mode = 0; cd_delay = 20;
        start_job(1'b0);
        wait_idle(20000);
        check_full_job("mode0");
        check("mode0_mode_q", 64'(mode_q), 64'd0);

        // mode 1, stream valid every other cycle
        valid_mode = 1; cd_delay = $urandom_range(1, 30);
        start_job(1'b1);
        wait_idle(20000);
        check_full_job("mode1");
        check("mode1_mode_q", 64'(mode_q), 64'd1);

        // random bubbles, stray compute_done in LD_IF, start pulse in LD_B
        valid_mode = 2; cd_delay = $urandom_range(1, 30);
        start_job(1'b0);
        stray_cd = 1'b1;
        wait_idx(NIF + NW + 10, 20000);
        start = 1'b1; mode = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_idle(20000);
        check_full_job("ignored_events");
        check("ignored_events_mode_q", 64'(mode_q), 64'd0);

        // abort together with the 500th weight word
        valid_mode = 0; cd_delay = 20;
        start_job(1'b0);
        wait_idx(NIF + 499, 20000);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_to_idle", 64'(busy), 64'd0);
        cyc(3);
        check("abort_weight_writes", 64'(n_w), 64'd499);
        check("abort_no_done", 64'(n_done), 64'd0);
        start_job(1'b1);
        wait_idle(20000);
        check_full_job("after_abort");

        // abort and start in the same IDLE cycle
        start = 1'b1; abort = 1'b1;
        cyc(1);
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);
        cyc(2);

        // asynchronous reset in the middle of the weight segment
        start_job(1'b1);
        wait_idx(NIF + 100, 20000);
        rst = 1'b0;
        #2;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        check("async_rst_weight_we", 64'(weight_we), 64'd0);
        check("async_rst_weight_addr", 64'(weight_addr), 64'd0);
        check("async_rst_wdata", 64'(wdata), 64'd0);
        check("async_rst_mode_q", 64'(mode_q), 64'd0);
        cyc(2);
        rst = 1'b1;
        cyc(2);
        check("post_rst_in_ready", 64'(in_ready), 64'd0);

`ifdef SEQ_TIMEOUT_EN
        // watchdog: compute_done withheld
        cd_withhold = 1'b1;
        start_job(1'b0);
        wait_idle(20000);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_no_done", 64'(n_done), 64'd0);
        cd_withhold = 1'b0; cd_delay = 20;
        start_job(1'b0);
        check("restart_clears_err", 64'(err), 64'd0);
        wait_idle(20000);
        check_full_job("after_timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mlp_load_sequencer.md
# mlp_load_sequencer

Front-end controller for the MLP accelerator top. It accepts the packed DRAM word stream (ifmap, then weights, then bias, once per step), decodes which segment each word belongs to, and issues write strobes and addresses to the ifmap, weight and bias global buffers. It starts the PE-array compute for each of the two steps of a job and reports job completion. It sits between the external `ready`/`data_in` interface and the GLB/PE-array datapath.

## Interface
- `DATA_W`, 32: stream and buffer word width (4 packed 8-bit values, or one 32-bit bias).
- `IF_WORDS`, 16: ifmap words per step.
- `W_WORDS`, 1024: weight words per step.
- `B_WORDS`, 64: bias words per step.
- `TIMEOUT_CYCLES`, 4096: compute watchdog limit (only with `SEQ_TIMEOUT_EN`).

Ports:
- `clk`  input  1  clock; all logic rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `mode`  input  1  0 = MLP0 (64→128), 1 = MLP3 (128→64); sampled on accepted `start`.
- `start`  input  1  job request pulse; accepted only in IDLE.
- `abort`  input  1  synchronous job cancel.
- `in_valid`  input  1  stream word present.
- `in_ready`  output  1  sequencer accepts a word this cycle.
- `data_in`  input  DATA_W  stream word.
- `ifmap_we`, `weight_we`, `bias_we`  output  1 each  buffer write strobes.
- `ifmap_addr`  output  $clog2(IF_WORDS)  ifmap write address.
- `weight_addr`  output  $clog2(W_WORDS)  weight write address.
- `bias_addr`  output  $clog2(B_WORDS)  bias write address.
- `wdata`  output  DATA_W  registered copy of the accepted word.
- `mode_q`  output  1  latched job mode, constant for the whole job.
- `step`  output  1  current step (0 or 1).
- `compute_start`  output  1  one-cycle PE-array kick.
- `compute_done`  input  1  PE array finished current step.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse at job end.
- `err`  output  1  sticky watchdog flag; cleared by reset or next accepted `start`.

## Operation
- States: IDLE, LD_IF, LD_W, LD_B, KICK, RUN.
- IDLE: on `start`, latch `mode` into `mode_q`, clear `step` and `err`, then go to LD_IF.
- LD_IF, LD_W, LD_B: `in_ready`=1. A word is accepted when `in_valid && in_ready`. One segment counter advances per accepted word. When the counter reaches IF_WORDS-1, W_WORDS-1 or B_WORDS-1 respectively, the counter clears and the state moves to LD_W, LD_B or KICK.
- Addresses equal the segment counter value at acceptance, so each segment starts at address 0 for every step.
- KICK: `compute_start`=1 for one cycle, then go to RUN.
- RUN: wait for `compute_done`.
  - If `step`=0: set `step`=1 and go to LD_IF.
  - If `step`=1: pulse `done` and go to IDLE.
- `mode_q` does not alter the sequencing; downstream uses it for output routing and accumulation.
- `in_valid` outside the LD states is not accepted, and no strobe fires.
- `compute_done` outside RUN is ignored.
- `start` while busy is ignored.
- `abort` in any state:
  - go to IDLE next cycle and clear all counters and `step`;
  - pending strobes are suppressed; no `done`.
  - `abort` has priority over every other event in the same cycle.
- `abort` and `start` in the same IDLE cycle: `abort` wins, and the job is not started.

## Timing
- Reset values: state IDLE; `in_ready`, all `*_we`, `compute_start`, `done`, `busy`, `err`, `step`, `mode_q` = 0; all addresses and `wdata` = 0.
- Write latency is 1 cycle: a word accepted in cycle N produces `*_we`=1 with matching `*_addr` and `wdata` in cycle N+1.
- `in_ready` is a registered function of state only, with no combinational path from `in_valid`.
- The last bias word accepted in cycle N gives:
  - bias write in N+1 (state KICK);
  - `compute_start` in N+1;
  - RUN from N+2.
- Bubbles (`in_valid`=0) stall counters without limit; there is no timeout on loading.
- Per step, 1104 words are accepted; minimum LD_IF→KICK time is 1104 cycles.
- `compute_done` in cycle M: the next state is taken at M+1. `done` is asserted in cycle M+1 together with `busy`=0.
- A new `start` is accepted at the earliest in the cycle after `done`.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - a RUN-state cycle counter, cleared on entry to RUN;
  - if it reaches TIMEOUT_CYCLES without `compute_done`, set `err`=1 and go to IDLE with no `done`.
- Undefined: no counter, RUN waits indefinitely, and `err` is tied to 0.

## Test plan
- Reset with `rst`=0 mid-LD_W → all outputs at reset values immediately; after release the state is IDLE and `in_ready`=0.
- Full job, mode 0, `in_valid` held high, `compute_done` returned 20 cycles after each `compute_start` →
  - 2×16 ifmap writes, 2×1024 weight writes and 2×64 bias writes, addresses 0..N-1 in order, `wdata` matching;
  - exactly 2 `compute_start` pulses and one `done`;
  - `mode_q`=0 throughout.
- Mode 1 job with `in_valid` toggled every other cycle → identical write sequence at half rate, `mode_q`=1, `step` 0→1 after the first `compute_done`.
- `start` pulsed in LD_B, plus stray `compute_done` in LD_IF → ignored; the write count and state sequence are unchanged.
- `abort` in the same cycle as the 500th weight word → no weight write for that word, IDLE next cycle; a subsequent `start` restarts at ifmap address 0.
- With `SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=64, `compute_done` withheld → `err`=1 after 64 RUN cycles, IDLE, no `done`; the next `start` clears `err`.
